// File: rtl/alu_control_fsm_if.sv
// Instruction-side and datapath-control signals of the multicycle sequencer.
// The slave modport is the sequencer; the master drives Run/DIN.
`timescale 1ns/1ps
interface alu_control_fsm_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic                  Run;
  logic [DATA_W-1:0]     DIN;
  logic                  IRin;
  logic [(1<<SEL_W)-1:0] Rin;
  logic [(1<<SEL_W)-1:0] Rout;
  logic                  DINout;
  logic                  Ain;
  logic                  Gin;
  logic                  Gout;
  logic [3:0]            aluSignal;
  logic                  Done;
  logic                  Busy;

  modport master (
    output Run, DIN,
    input  IRin, Rin, Rout, DINout, Ain, Gin,
    input  Gout, aluSignal, Done, Busy
  );

  modport slave (
    input  Run, DIN,
    output IRin, Rin, Rout, DINout, Ain, Gin,
    output Gout, aluSignal, Done, Busy
  );
endinterface

// File: rtl/alu_control_fsm.sv
// Multicycle T0..T3 sequencer: latches an instruction into IR and
// emits register/A/G/bus controls plus the ALU op code per time slot.
`timescale 1ns/1ps
module alu_control_fsm #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic Clock,
  input  logic Resetn,
  alu_control_fsm_if.slave bus
);
  localparam int NREG = 1 << SEL_W;
  localparam int RX_HI = DATA_W - 4;
  localparam int RY_HI = DATA_W - 4 - SEL_W;
  localparam int LO_W = DATA_W - 3 - 2 * SEL_W;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [2:0]        op;
  logic [SEL_W-1:0]  rx, ry;
  logic              is_mv, is_mvi;
  logic [3:0]        alu_code;

  logic              irin, dinout, ain, gin, gout, done;
  logic [NREG-1:0]   rin, rout;
  logic [3:0]        alu;

  assign op = ir_q[DATA_W-1 -: 3];
  assign rx = ir_q[RX_HI -: SEL_W];
  assign ry = ir_q[RY_HI -: SEL_W];
  assign is_mv  = (op == 3'b000);
  assign is_mvi = (op == 3'b001);

  // Low IR bits carry no control information.
  logic unused_ir;
  assign unused_ir = ^ir_q[LO_W-1:0];

  always_comb begin
    alu_code = 4'b0000;
    unique case (op)
      3'b011:  alu_code = 4'b0001;
      3'b100:  alu_code = 4'b0010;
      3'b101:  alu_code = 4'b0011;
      3'b110:  alu_code = 4'b0100;
      3'b111:  alu_code = 4'b0101;
      default: alu_code = 4'b0000;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    irin    = 1'b0;
    rin     = '0;
    rout    = '0;
    dinout  = 1'b0;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    alu     = 4'b0000;
    done    = 1'b0;
    unique case (state_q)
      T0: begin
        if (bus.Run) begin
          irin    = 1'b1;
          ir_d    = bus.DIN;
          state_d = T1;
        end
      end
      T1: begin
        unique case (1'b1)
          is_mv: begin
            rout[ry] = 1'b1;
            rin[rx]  = 1'b1;
            done     = 1'b1;
            state_d  = T0;
          end
          is_mvi: begin
            dinout  = 1'b1;
            rin[rx] = 1'b1;
            done    = 1'b1;
            state_d = T0;
          end
          default: begin
            rout[rx] = 1'b1;
            ain      = 1'b1;
            state_d  = T2;
          end
        endcase
      end
      T2: begin
        rout[ry] = 1'b1;
        gin      = 1'b1;
        alu      = alu_code;
        state_d  = T3;
      end
      T3: begin
        gout    = 1'b1;
        rin[rx] = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  // Only IRin can be nonzero in T0, so gating it silences reset.
  assign bus.IRin      = irin & Resetn;
  assign bus.Rin       = rin;
  assign bus.Rout      = rout;
  assign bus.DINout    = dinout;
  assign bus.Ain       = ain;
  assign bus.Gin       = gin;
  assign bus.Gout      = gout;
  assign bus.aluSignal = alu;
  assign bus.Done      = done;
  assign bus.Busy      = (state_q != T0);
endmodule

// File: tb/tb_alu_control_fsm.sv
// Directed-vector bench for the T0..T3 control sequencer.
`timescale 1ns/1ps
module tb_alu_control_fsm;
  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  int   nchk = 0;
  int   nfail = 0;

  alu_control_fsm_if #(.DATA_W(16), .SEL_W(3)) bus ();

  alu_control_fsm #(.DATA_W(16), .SEL_W(3)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.slave)
  );

  always #5 Clock = ~Clock;

  logic [26:0] obs;
  assign obs = {bus.IRin, bus.Rin, bus.Rout, bus.DINout, bus.Ain,
                bus.Gin, bus.Gout, bus.aluSignal, bus.Done, bus.Busy};

  function automatic logic [26:0] pk(
    input logic irin, input logic [7:0] rin, input logic [7:0] rout,
    input logic dinout, input logic ain, input logic gin,
    input logic gout, input logic [3:0] alu, input logic done,
    input logic busy);
    return {irin, rin, rout, dinout, ain, gin, gout, alu, done, busy};
  endfunction

  function automatic logic [7:0] oh(input int i);
    return 8'(1) << i;
  endfunction

  function automatic logic [15:0] enc(input int op, input int rx,
                                      input int ry);
    return {3'(op), 3'(rx), 3'(ry), 7'b0};
  endfunction

  task automatic nxt();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [26:0] e;
    Resetn = 1'b0;
    bus.Run = 1'b1;
    bus.DIN = 16'h4A80;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    e = '0;
    if (obs !== e) begin
      nfail++;
      $display("FAIL reset_hold got=%h exp=%h", obs, e);
    end
    nchk++;
    nxt();
    Resetn = 1'b1;
    @(negedge Clock);
    e = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== e) begin
      nfail++;
      $display("FAIL reset_release got=%h exp=%h", obs, e);
    end
    nchk++;
    nxt();
    bus.Run = 1'b0;
    @(negedge Clock);
    e = pk(0, 0, oh(2), 0, 1, 0, 0, 0, 0, 1);
    if (obs !== e) begin
      nfail++;
      $display("FAIL reset_first_t1 got=%h exp=%h", obs, e);
    end
    nchk++;
    repeat (3) nxt();
    @(negedge Clock);
    e = '0;
    if (obs !== e) begin
      nfail++;
      $display("FAIL reset_idle got=%h exp=%h", obs, e);
    end
    nchk++;
  endtask

  task automatic test_mvi();
    logic [26:0] e;
    nxt();
    bus.Run = 1'b1;
    bus.DIN = 16'h2800;
    @(negedge Clock);
    e = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== e) begin
      nfail++;
      $display("FAIL mvi_t0 got=%h exp=%h", obs, e);
    end
    nchk++;
    nxt();
    bus.Run = 1'b0;
    bus.DIN = 16'h1234;
    @(negedge Clock);
    e = pk(0, 8'h04, 0, 1, 0, 0, 0, 0, 1, 1);
    if (obs !== e) begin
      nfail++;
      $display("FAIL mvi_t1 got=%h exp=%h", obs, e);
    end
    nchk++;
    nxt();
    @(negedge Clock);
    e = '0;
    if (obs !== e) begin
      nfail++;
      $display("FAIL mvi_after got=%h exp=%h", obs, e);
    end
    nchk++;
  endtask

  task automatic test_add();
    logic [26:0] e;
    nxt();
    bus.Run = 1'b1;
    bus.DIN = 16'h4680;
    @(negedge Clock);
    e = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (obs !== e) begin
      nfail++;
      $display("FAIL add_t0 got=%h exp=%h", obs, e);
    end
    nchk++;
    nxt();
    bus.Run = 1'b0;
    bus.DIN = 16'hFFFF;
    @(negedge Clock);
    e = pk(0, 0, 8'h02, 0, 1, 0, 0, 0, 0, 1);
    if (obs !== e) begin
      nfail++;
      $display("FAIL add_t1 got=%h exp=%h", obs, e);
    end
    nchk++;
    nxt();
    @(negedge Clock);
    e = pk(0, 0, 8'h20, 0, 0, 1, 0, 4'b0000, 0, 1);
    if (obs !== e) begin
      nfail++;
      $display("FAIL add_t2 got=%h exp=%h", obs, e);
    end
    nchk++;
    nxt();
    @(negedge Clock);
    e = pk(0, 8'h02, 0, 0, 0, 0, 1, 0, 1, 1);
    if (obs !== e) begin
      nfail++;
      $display("FAIL add_t3 got=%h exp=%h", obs, e);
    end
    nchk++;
  endtask

  task automatic test_alu_sweep();
    int ops[6] = '{2, 3, 4, 5, 6, 7};
    int rxs[6] = '{3, 3, 4, 5, 6, 7};
    int rys[6] = '{3, 4, 5, 6, 7, 0};
    logic [3:0] alus[6] = '{4'b0000, 4'b0001, 4'b0010,
                            4'b0011, 4'b0100, 4'b0101};
    logic [26:0] e;
    int drv;
    for (int k = 0; k < 6; k++) begin
      nxt();
      bus.Run = 1'b1;
      bus.DIN = enc(ops[k], rxs[k], rys[k]);
      nxt();
      bus.Run = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge Clock);
        drv = $countones(bus.Rout) + int'(bus.DINout) + int'(bus.Gout);
        if (drv > 1 || $countones(bus.Rin) > 1) begin
          nfail++;
          $display("FAIL bus_excl op%0d t%0d got=%0d exp<=1",
                   ops[k], c, drv);
        end
        nchk++;
        if (c == 1) e = pk(0, 0, oh(rxs[k]), 0, 1, 0, 0, 0, 0, 1);
        else if (c == 2) e = pk(0, 0, oh(rys[k]), 0, 0, 1, 0,
                                alus[k], 0, 1);
        else e = pk(0, oh(rxs[k]), 0, 0, 0, 0, 1, 0, 1, 1);
        if (obs !== e) begin
          nfail++;
          $display("FAIL sweep op%0d t%0d got=%h exp=%h",
                   ops[k], c, obs, e);
        end
        nchk++;
        if (c < 3) nxt();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] exp_seq[7];
    exp_seq[0] = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_seq[1] = pk(0, oh(6), oh(1), 0, 0, 0, 0, 0, 1, 1);
    exp_seq[2] = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_seq[3] = pk(0, 0, oh(0), 0, 1, 0, 0, 0, 0, 1);
    exp_seq[4] = pk(0, 0, oh(7), 0, 0, 1, 0, 4'b0101, 0, 1);
    exp_seq[5] = pk(0, oh(0), 0, 0, 0, 0, 1, 0, 1, 1);
    exp_seq[6] = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt();
    bus.Run = 1'b1;
    bus.DIN = enc(0, 6, 1);
    for (int c = 0; c < 7; c++) begin
      @(negedge Clock);
      if (obs !== exp_seq[c]) begin
        nfail++;
        $display("FAIL b2b c%0d got=%h exp=%h", c, obs, exp_seq[c]);
      end
      nchk++;
      if (c == 6) bus.Run = 1'b0;
      else begin
        nxt();
        bus.DIN = enc(7, 0, 7);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [26:0] e;
    nxt();
    bus.Run = 1'b1;
    bus.DIN = enc(3, 4, 2);
    nxt();
    bus.Run = 1'b0;
    nxt();
    @(negedge Clock);
    e = pk(0, 0, oh(2), 0, 0, 1, 0, 4'b0001, 0, 1);
    if (obs !== e) begin
      nfail++;
      $display("FAIL mid_t2 got=%h exp=%h", obs, e);
    end
    nchk++;
    #2;
    Resetn = 1'b0;
    #1;
    e = '0;
    if (obs !== e) begin
      nfail++;
      $display("FAIL mid_drop got=%h exp=%h", obs, e);
    end
    nchk++;
    nxt();
    @(negedge Clock);
    if (obs !== e) begin
      nfail++;
      $display("FAIL mid_hold got=%h exp=%h", obs, e);
    end
    nchk++;
    nxt();
    Resetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clock);
      if (obs !== e) begin
        nfail++;
        $display("FAIL mid_no_rin c%0d got=%h exp=%h", c, obs, e);
      end
      nchk++;
      nxt();
    end
    bus.Run = 1'b1;
    bus.DIN = enc(0, 5, 5);
    nxt();
    bus.Run = 1'b0;
    @(negedge Clock);
    e = pk(0, oh(5), oh(5), 0, 0, 0, 0, 0, 1, 1);
    if (obs !== e) begin
      nfail++;
      $display("FAIL mid_restart got=%h exp=%h", obs, e);
    end
    nchk++;
  endtask

  initial begin
    bus.Run = 1'b0;
    bus.DIN = '0;
    test_reset();
    test_mvi();
    test_add();
    test_alu_sweep();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule

// File: doc/alu_control_fsm.md
Name: alu_control_fsm

Overview:
- Multicycle control sequencer that drives the datapath ALU and the shared 16-bit bus.
- Accepts one instruction word on DIN when Run is high and latches it into an internal IR.
- Steps through time slots T0..T3, generating register in/out enables, A/G load strobes, the G bus drive and the 4-bit aluSignal code the ALU decodes.
- Sits between the instruction source and the register file / A / ALU / G datapath; asserts Done when the instruction retires.

Parameters:
DATA_W, 16, width of DIN and the internal IR
SEL_W, 3, register-select field width; the register count is 2**SEL_W (8)

Ports:
Clock  input  1  rising-edge system clock
Resetn  input  1  asynchronous, active-low reset
Run  input  1  start request; sampled only in T0
DIN  input  DATA_W  instruction word (sampled in T0); immediate data (valid in T1 for mvi)
IRin  output  1  high in the cycle IR captures DIN
Rin  output  2**SEL_W  one-hot register load enables
Rout  output  2**SEL_W  one-hot register bus drive enables
DINout  output  1  DIN drives the bus
Ain  output  1  load A from the bus
Gin  output  1  load G from the ALU output
Gout  output  1  G drives the bus
aluSignal  output  4  ALU op code
Done  output  1  instruction retires this cycle
Busy  output  1  state is not T0

Behaviour:
- Reset (Resetn=0, asynchronous): state=T0, IR=0. All outputs are forced to 0 while Resetn=0, independent of Run. Reset during T1..T3 abandons the instruction with no Rin pulse.
- IR format: opcode=IR[DATA_W-1:DATA_W-3], rX=next SEL_W bits, rY=following SEL_W bits; remaining bits ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 or, 101 slt, 110 sll, 111 srl.
- aluSignal map: add 0000, sub 0001, or 0010, slt 0011, sll 0100, srl 0101.
- Outputs are combinational decodes of (state, IR). IRin additionally depends on Run in T0.
- T0:
  - Run=1: IRin=1, IR<=DIN at the edge, next state T1.
  - Run=0: all outputs 0, stay in T0.
- T1:
  - mv: Rout[rY]=1, Rin[rX]=1, Done=1, next T0.
  - mvi: DINout=1, Rin[rX]=1, Done=1, next T0.
  - ALU ops: Rout[rX]=1, Ain=1, next T2.
- T2 (ALU ops only): Rout[rY]=1, Gin=1, aluSignal=op code, next T3.
- T3: Gout=1, Rin[rX]=1, Done=1, next T0.
- aluSignal=0000 in every cycle where Gin=0.
- Latency from the T0 accept edge: mv/mvi retire 1 cycle later; ALU ops retire 3 cycles later.
- Throughput: a new instruction can be accepted in the T0 cycle immediately after Done.
- Run is ignored in T1..T3, and DIN changes are ignored outside T0 (and outside T1 for mvi).
- Bus exclusivity: at most one of {any Rout bit, DINout, Gout} is high in any cycle. Rin is at most one-hot.
- rX==rY is legal: the same register is driven and loaded (e.g. add r3,r3 doubles r3).
- Busy=1 exactly in T1, T2 and T3.

Test Plan:
- Hold Resetn=0 with Run=1 and DIN=0x4A80 -> all outputs 0; release reset -> IRin=1 in the first cycle.
- mvi r2 (DIN=0x2800, then DIN=0x1234 in T1) -> T1 shows DINout=1, Rin=0000_0100, Done=1; next cycle Busy=0.
- add r1,r5 (DIN=0x4680) -> T1: Rout=0x02, Ain=1; T2: Rout=0x20, Gin=1, aluSignal=0000; T3: Gout=1, Rin=0x02, Done=1.
- Sweep sub, or, slt, sll, srl -> T2 aluSignal is 0001, 0010, 0011, 0100, 0101 respectively. Every cycle has at most one bus driver.
- Hold Run=1 continuously over back-to-back mv and srl -> IRin is asserted in the cycle after each Done, and there are no idle gaps.
- Pulse Resetn=0 in T2 of a sub -> outputs drop immediately, there is no Rin pulse, and the FSM restarts in T0.
